td4_core: RTL and testbench

TD4_CORE -- requirements
Module: td4_core

---
 rtl/td4_pkg.sv | 38 +++
 rtl/td4_decode.sv | 43 ++++
 rtl/td4_core.sv | 108 ++++++++++
 tb/tb_td4_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 4-bit CPU core: instruction field widths,
// opcode constants, ALU source encoding and the 5-bit adder helper.
package td4_pkg;

   localparam int INSN_W = 8;
   localparam int OPC_W  = 4;
   localparam int IMM_W  = 4;
   localparam int DATA_W = 4;
   localparam int PC_W   = 4;

   localparam logic [OPC_W-1:0] OP_ADD_A_IM = 4'b0000;
   localparam logic [OPC_W-1:0] OP_MOV_A_B  = 4'b0001;
   localparam logic [OPC_W-1:0] OP_IN_A     = 4'b0010;
   localparam logic [OPC_W-1:0] OP_MOV_A_IM = 4'b0011;
   localparam logic [OPC_W-1:0] OP_MOV_B_A  = 4'b0100;
   localparam logic [OPC_W-1:0] OP_ADD_B_IM = 4'b0101;
   localparam logic [OPC_W-1:0] OP_IN_B     = 4'b0110;
   localparam logic [OPC_W-1:0] OP_MOV_B_IM = 4'b0111;
   localparam logic [OPC_W-1:0] OP_OUT_B    = 4'b1001;
   localparam logic [OPC_W-1:0] OP_OUT_IM   = 4'b1011;
   localparam logic [OPC_W-1:0] OP_JNC_IM   = 4'b1110;
   localparam logic [OPC_W-1:0] OP_JMP_IM   = 4'b1111;

   // Register operand feeding the adder; the other operand is Im or zero.
   typedef enum logic [1:0] {
      SRC_A    = 2'd0,
      SRC_B    = 2'd1,
      SRC_IN   = 2'd2,
      SRC_ZERO = 2'd3
   } src_sel_t;

   // 5-bit sum of two 4-bit operands; bit 4 is the carry out.
   function automatic logic [DATA_W:0] add5(input logic [DATA_W-1:0] x,
                                            input logic [DATA_W-1:0] y);
      return {1'b0, x} + {1'b0, y};
   endfunction

endpackage

// File: rtl/td4_decode.sv
// Combinational instruction decoder for the TD4 core. Undefined opcodes
// fall into the default arm and behave as NOP (only PC+1, carry cleared).
module td4_decode
   import td4_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   input  logic             c,
   output logic             load_a,
   output logic             load_b,
   output logic             load_out,
   output logic             load_pc,
   output logic             use_imm,
   output logic             is_add,
   output src_sel_t         src_sel
);

   // Map each opcode to register-load strobes and adder operand selection.
   always_comb begin
      load_a   = 1'b0;
      load_b   = 1'b0;
      load_out = 1'b0;
      load_pc  = 1'b0;
      use_imm  = 1'b0;
      is_add   = 1'b0;
      src_sel  = SRC_ZERO;
      case (opcode)
         OP_ADD_A_IM: begin load_a = 1'b1; src_sel = SRC_A;  use_imm = 1'b1; is_add = 1'b1; end
         OP_MOV_A_B:  begin load_a = 1'b1; src_sel = SRC_B;  end
         OP_IN_A:     begin load_a = 1'b1; src_sel = SRC_IN; end
         OP_MOV_A_IM: begin load_a = 1'b1; use_imm = 1'b1;   end
         OP_MOV_B_A:  begin load_b = 1'b1; src_sel = SRC_A;  end
         OP_ADD_B_IM: begin load_b = 1'b1; src_sel = SRC_B;  use_imm = 1'b1; is_add = 1'b1; end
         OP_IN_B:     begin load_b = 1'b1; src_sel = SRC_IN; end
         OP_MOV_B_IM: begin load_b = 1'b1; use_imm = 1'b1;   end
         OP_OUT_B:    begin load_out = 1'b1; src_sel = SRC_B; end
         OP_OUT_IM:   begin load_out = 1'b1; use_imm = 1'b1;  end
         OP_JNC_IM:   begin load_pc = ~c; end
         OP_JMP_IM:   begin load_pc = 1'b1; end
         default:     begin load_pc = 1'b0; end
      endcase
   end

endmodule

// File: rtl/td4_core.sv
// TD4 4-bit CPU core: zero-latency fetch from an external combinational ROM,
// one instruction per execute cycle. Optional macro TD4_PRESCALE_EN adds a
// 0..PRESCALE-1 counter so an instruction executes only every PRESCALE clocks.
module td4_core
   import td4_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [PC_W-1:0]   rom_addr,
   input  logic [INSN_W-1:0] rom_data,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              carry
);

   logic [PC_W-1:0]   pc_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [DATA_W-1:0] out_r;
   logic              c_r;
   logic              exec_s;

   logic [OPC_W-1:0]  opcode_s;
   logic [IMM_W-1:0]  imm_s;
   logic              load_a_s, load_b_s, load_out_s, load_pc_s, use_imm_s, is_add_s;
   src_sel_t          src_sel_s;
   logic [DATA_W-1:0] src_val_s;
   logic [DATA_W-1:0] opnd_s;
   logic [DATA_W:0]   sum_s;

   assign opcode_s = rom_data[INSN_W-1 -: OPC_W];
   assign imm_s    = rom_data[IMM_W-1:0];
   assign rom_addr = pc_r;
   assign out_port = out_r;
   assign carry    = c_r;

`ifdef TD4_PRESCALE_EN
   logic [15:0] cnt_r;

   assign exec_s = (cnt_r == 16'(PRESCALE - 1));

   // Prescale counter: wraps to zero on the execute cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 16'd0;
      end else if (exec_s) begin
         cnt_r <= 16'd0;
      end else begin
         cnt_r <= cnt_r + 16'd1;
      end
   end
`else
   logic [15:0] unused_prescale_s;

   assign unused_prescale_s = 16'(PRESCALE);
   assign exec_s            = 1'b1;
`endif

   td4_decode u_decode (
      .opcode   (opcode_s),
      .c        (c_r),
      .load_a   (load_a_s),
      .load_b   (load_b_s),
      .load_out (load_out_s),
      .load_pc  (load_pc_s),
      .use_imm  (use_imm_s),
      .is_add   (is_add_s),
      .src_sel  (src_sel_s)
   );

   // Adder operand selection: register source plus Im (or zero for moves).
   always_comb begin
      src_val_s = {DATA_W{1'b0}};
      case (src_sel_s)
         SRC_A:    src_val_s = a_r;
         SRC_B:    src_val_s = b_r;
         SRC_IN:   src_val_s = in_port;
         SRC_ZERO: src_val_s = {DATA_W{1'b0}};
         default:  src_val_s = {DATA_W{1'b0}};
      endcase
      if (use_imm_s) begin
         opnd_s = imm_s;
      end else begin
         opnd_s = {DATA_W{1'b0}};
      end
      sum_s = add5(src_val_s, opnd_s);
   end

   // Architectural state: all registers update together on an execute edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r  <= {PC_W{1'b0}};
         a_r   <= {DATA_W{1'b0}};
         b_r   <= {DATA_W{1'b0}};
         out_r <= {DATA_W{1'b0}};
         c_r   <= 1'b0;
      end else if (exec_s) begin
         pc_r <= load_pc_s ? imm_s : (pc_r + 4'd1);
         c_r  <= is_add_s ? sum_s[DATA_W] : 1'b0;
         if (load_a_s)   a_r   <= sum_s[DATA_W-1:0];
         if (load_b_s)   b_r   <= sum_s[DATA_W-1:0];
         if (load_out_s) out_r <= sum_s[DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_td4_core.sv
// Scoreboard bench for td4_core: stimulus pushes hand-computed post-step
// state {pc, A, B, C, out}; a monitor pops and compares on the falling edge.
module tb_td4_core;

`ifdef TD4_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic [3:0] in_port = 4'h0;
   logic [3:0] out_port;
   logic       carry;
   logic [7:0] rom [16];

   typedef struct packed {
      logic [3:0] pc;
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [3:0] o;
   } st_t;

   st_t exp_q[$];
   int  tag_q[$];
   int  checks = 0;
   int  failures = 0;
   int  step_no = 0;

   td4_core #(.PRESCALE(PS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .in_port  (in_port),
      .out_port (out_port),
      .carry    (carry)
   );

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   function automatic st_t actual();
      st_t s;
      s.pc = rom_addr;
      s.a  = dut.a_r;
      s.b  = dut.b_r;
      s.c  = carry;
      s.o  = out_port;
      return s;
   endfunction

   // Monitor: compare DUT state against the oldest expected entry.
   always @(negedge clk) begin : mon
      st_t e;
      st_t s;
      int  t;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         s = actual();
         checks++;
         if (s !== e) begin
            failures++;
            $display("FAIL step%0d pc/a/b/c/out actual=%h/%h/%h/%b/%h expected=%h/%h/%h/%b/%h",
                     t, s.pc, s.a, s.b, s.c, s.o, e.pc, e.a, e.b, e.c, e.o);
         end
      end
   end

   task automatic step(input logic [3:0] pc, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] o);
      repeat (PS) @(posedge clk);
      step_no++;
      exp_q.push_back({pc, a, b, c, o});
      tag_q.push_back(step_no);
   endtask

   task automatic check_zero(input string name);
      st_t s;
      s = actual();
      checks++;
      if (s !== 17'd0) begin
         failures++;
         $display("FAIL %s pc/a/b/c/out actual=%h/%h/%h/%b/%h expected=all zero",
                  name, s.pc, s.a, s.b, s.c, s.o);
      end
   endtask

   task automatic fill_rom(input logic [7:0] v);
      for (int i = 0; i < 16; i++) rom[i] = v;
   endtask

   // Assert reset between edges, check the cleared state, then release.
   task automatic reset_between(input string name);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_zero(name);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      // LED pattern
      fill_rom(8'h80);
      rom[0] = 8'hB3; rom[1] = 8'hB6; rom[2] = 8'hBC; rom[3] = 8'hB8; rom[4] = 8'hF0;
      #12 check_zero("reset");
      release_reset();
      step(4'h1, 4'h0, 4'h0, 1'b0, 4'h3);
      step(4'h2, 4'h0, 4'h0, 1'b0, 4'h6);
      step(4'h3, 4'h0, 4'h0, 1'b0, 4'hC);
      step(4'h4, 4'h0, 4'h0, 1'b0, 4'h8);
      step(4'h0, 4'h0, 4'h0, 1'b0, 4'h8);
      step(4'h1, 4'h0, 4'h0, 1'b0, 4'h3);

      // Carry and JNC taken / not taken
      reset_between("reset_t2");
      fill_rom(8'h80);
      rom[0] = 8'h3E; rom[1] = 8'h01; rom[2] = 8'hE1;
      release_reset();
      step(4'h1, 4'hE, 4'h0, 1'b0, 4'h0);
      step(4'h2, 4'hF, 4'h0, 1'b0, 4'h0);
      step(4'h1, 4'hF, 4'h0, 1'b0, 4'h0);
      step(4'h2, 4'h0, 4'h0, 1'b1, 4'h0);
      step(4'h3, 4'h0, 4'h0, 1'b0, 4'h0);
      step(4'h4, 4'h0, 4'h0, 1'b0, 4'h0);

      // Data paths through B
      reset_between("reset_t3");
      fill_rom(8'h80);
      rom[0] = 8'h60; rom[1] = 8'h10; rom[2] = 8'h07; rom[3] = 8'h90;
      in_port = 4'hA;
      release_reset();
      step(4'h1, 4'h0, 4'hA, 1'b0, 4'h0);
      step(4'h2, 4'hA, 4'hA, 1'b0, 4'h0);
      step(4'h3, 4'h1, 4'hA, 1'b1, 4'h0);
      step(4'h4, 4'h1, 4'hA, 1'b0, 4'hA);

      // Remaining opcodes, JMP to 15 and wrap after ADD with carry
      reset_between("reset_t4");
      fill_rom(8'h80);
      rom[0] = 8'h20; rom[1] = 8'h75; rom[2] = 8'h5C; rom[3] = 8'h40;
      rom[4] = 8'h90; rom[5] = 8'h3D; rom[6] = 8'hB2; rom[7] = 8'hFF;
      rom[15] = 8'h03;
      in_port = 4'h6;
      release_reset();
      step(4'h1, 4'h6, 4'h0, 1'b0, 4'h0);
      step(4'h2, 4'h6, 4'h5, 1'b0, 4'h0);
      step(4'h3, 4'h6, 4'h1, 1'b1, 4'h0);
      step(4'h4, 4'h6, 4'h6, 1'b0, 4'h0);
      step(4'h5, 4'h6, 4'h6, 1'b0, 4'h6);
      step(4'h6, 4'hD, 4'h6, 1'b0, 4'h6);
      step(4'h7, 4'hD, 4'h6, 1'b0, 4'h2);
      step(4'hF, 4'hD, 4'h6, 1'b0, 4'h2);
      step(4'h0, 4'h0, 4'h6, 1'b1, 4'h2);
      step(4'h1, 4'h6, 4'h6, 1'b0, 4'h2);

      // NOP sweep with PC wrap, state held
      reset_between("reset_t5");
      rom[0] = 8'h35; rom[1] = 8'h79; rom[2] = 8'hB7;
      for (int i = 3; i < 16; i++) begin
         case (i % 4)
            0:       rom[i] = 8'h80;
            1:       rom[i] = 8'hA0;
            2:       rom[i] = 8'hC0;
            default: rom[i] = 8'hD0;
         endcase
      end
      release_reset();
      step(4'h1, 4'h5, 4'h0, 1'b0, 4'h0);
      step(4'h2, 4'h5, 4'h9, 1'b0, 4'h0);
      step(4'h3, 4'h5, 4'h9, 1'b0, 4'h7);
      for (int k = 4; k <= 16; k++) step(4'(k), 4'h5, 4'h9, 1'b0, 4'h7);
      for (int k = 1; k <= 6; k++) step(4'(k), 4'h5, 4'h9, 1'b0, 4'h7);

      // Asynchronous reset at PC=6, held across an edge, then resume from 0
      reset_between("async_rst");
      @(posedge clk);
      #1 check_zero("held_rst");
      release_reset();
      step(4'h1, 4'h5, 4'h0, 1'b0, 4'h0);
      step(4'h2, 4'h5, 4'h9, 1'b0, 4'h0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
